// File: rtl/min_max_pkg.sv
// Shared types for the min/max display controller: display mode codes and sequencer states.
package min_max_pkg;

  typedef enum logic [1:0] {
    COM_NORMAL  = 2'b00,
    COM_LINEAR  = 2'b01,
    COM_ALL_OFF = 2'b10,
    COM_ALL_ON  = 2'b11
  } com_t;

  typedef enum logic [1:0] {
    TEST_ON,
    TEST_OFF,
    RUN
  } seq_state_t;

  // Counter width for a modulo-n count; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/min_max_sequencer_if.sv
// Request/status bundle between a host and min_max_sequencer, plus the drive towards min_max_top.
interface min_max_sequencer_if #(
  parameter int unsigned VALSIZE = 4
);
  import min_max_pkg::*;

  logic               cfg_valid_i;
  logic               cfg_ready_o;
  logic [VALSIZE-1:0] cfg_min_i;
  logic [VALSIZE-1:0] cfg_max_i;
  logic               cfg_err_o;
  logic               val_valid_i;
  logic [VALSIZE-1:0] val_i;
  logic               linear_i;
  logic               test_req_i;
  logic               busy_o;
  com_t               com_o;
  logic [VALSIZE-1:0] min_o;
  logic [VALSIZE-1:0] max_o;
  logic [VALSIZE-1:0] val_o;
  logic               osc_o;

  modport master (
    output cfg_valid_i, cfg_min_i, cfg_max_i, val_valid_i, val_i, linear_i, test_req_i,
    input  cfg_ready_o, cfg_err_o, busy_o, com_o, min_o, max_o, val_o, osc_o
  );

  modport slave (
    input  cfg_valid_i, cfg_min_i, cfg_max_i, val_valid_i, val_i, linear_i, test_req_i,
    output cfg_ready_o, cfg_err_o, busy_o, com_o, min_o, max_o, val_o, osc_o
  );

endinterface

// File: rtl/min_max_blink_gen.sv
// Blink generator: free-running prescaler that toggles osc_o on every wrap.
module min_max_blink_gen
  import min_max_pkg::*;
#(
  parameter int unsigned BLINK_DIV = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic osc_o
);

  localparam int unsigned PW = cnt_width(BLINK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(BLINK_DIV - 1);

  logic [PW-1:0] presc_q;
  logic          osc_q;

  // Clear wins over a wrap in the same cycle so a new config always restarts the phase low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
      osc_q   <= 1'b0;
    end else if (clr_i) begin
      presc_q <= '0;
      osc_q   <= 1'b0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
      osc_q   <= ~osc_q;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

  assign osc_o = osc_q;

endmodule

// File: rtl/min_max_sequencer.sv
// Drives min_max_top: lamp test after reset or on request, then validated min/max config,
// value forwarding and the osc blink.
module min_max_sequencer
  import min_max_pkg::*;
#(
  parameter int unsigned VALSIZE     = 4,
  parameter int unsigned BLINK_DIV   = 8,
  parameter int unsigned TEST_CYCLES = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  min_max_sequencer_if.slave  bus
);

  localparam int unsigned CW = cnt_width(TEST_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TEST_CYCLES - 1);

  seq_state_t         state_q;
  logic [CW-1:0]      cnt_q;
  com_t               com_q;
  logic               busy_q;
  logic               ready_q;
  logic [VALSIZE-1:0] min_q;
  logic [VALSIZE-1:0] max_q;
  logic [VALSIZE-1:0] val_q;
  logic               err_q;
  logic               cfg_accept;
  logic               cfg_ok;

  // ready_q is high only in RUN, so this also gates requests made during the lamp test.
  assign cfg_accept = bus.cfg_valid_i & ready_q;
  assign cfg_ok     = bus.cfg_min_i < bus.cfg_max_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= TEST_ON;
      cnt_q   <= '0;
      com_q   <= COM_ALL_ON;
      busy_q  <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        TEST_ON: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= TEST_OFF;
            cnt_q   <= '0;
            com_q   <= COM_ALL_OFF;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        TEST_OFF: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= RUN;
            cnt_q   <= '0;
            com_q   <= bus.linear_i ? COM_LINEAR : COM_NORMAL;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RUN: begin
          if (bus.test_req_i) begin
            state_q <= TEST_ON;
            cnt_q   <= '0;
            com_q   <= COM_ALL_ON;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end else begin
            com_q <= bus.linear_i ? COM_LINEAR : COM_NORMAL;
          end
        end
        default: begin
          state_q <= TEST_ON;
          cnt_q   <= '0;
          com_q   <= COM_ALL_ON;
          busy_q  <= 1'b1;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      min_q <= '0;
      max_q <= '1;
      val_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= cfg_accept & ~cfg_ok;
      if (cfg_accept && cfg_ok) begin
        min_q <= bus.cfg_min_i;
        max_q <= bus.cfg_max_i;
      end
      if (bus.val_valid_i) begin
        val_q <= bus.val_i;
      end
    end
  end

  min_max_blink_gen #(
    .BLINK_DIV (BLINK_DIV)
  ) u_blink (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cfg_accept & cfg_ok),
    .osc_o  (bus.osc_o)
  );

  assign bus.com_o       = com_q;
  assign bus.busy_o      = busy_q;
  assign bus.cfg_ready_o = ready_q;
  assign bus.cfg_err_o   = err_q;
  assign bus.min_o       = min_q;
  assign bus.max_o       = max_q;
  assign bus.val_o       = val_q;

endmodule

// File: tb/tb_min_max_sequencer.sv
// Directed bench for min_max_sequencer with VALSIZE=4, BLINK_DIV=4, TEST_CYCLES=3.
module tb_min_max_sequencer;
  import min_max_pkg::*;

  typedef struct {
    logic       cv;
    logic [3:0] cmin;
    logic [3:0] cmax;
    logic       vv;
    logic [3:0] v;
    logic       lin;
    logic       treq;
    logic [1:0] com;
    logic [3:0] mn;
    logic [3:0] mx;
    logic [3:0] vo;
    logic       err;
    logic       rdy;
    logic       busy;
    logic       osc;
  } vec_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  vec_t vecs[$];

  min_max_sequencer_if #(.VALSIZE(4)) bus ();

  min_max_sequencer #(
    .VALSIZE     (4),
    .BLINK_DIV   (4),
    .TEST_CYCLES (3)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic cv, input logic [3:0] cmin, input logic [3:0] cmax,
                     input logic vv, input logic [3:0] v, input logic lin, input logic treq,
                     input logic [1:0] com, input logic [3:0] mn, input logic [3:0] mx,
                     input logic [3:0] vo, input logic err, input logic rdy, input logic busy,
                     input logic osc);
    vec_t e;
    e = '{cv, cmin, cmax, vv, v, lin, treq, com, mn, mx, vo, err, rdy, busy, osc};
    vecs.push_back(e);
  endtask

  task automatic drive(input logic cv, input logic [3:0] cmin, input logic [3:0] cmax,
                       input logic vv, input logic [3:0] v, input logic lin, input logic treq);
    bus.cfg_valid_i = cv;
    bus.cfg_min_i   = cmin;
    bus.cfg_max_i   = cmax;
    bus.val_valid_i = vv;
    bus.val_i       = v;
    bus.linear_i    = lin;
    bus.test_req_i  = treq;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] com, input logic [3:0] mn,
                         input logic [3:0] mx, input logic [3:0] vo, input logic err,
                         input logic rdy, input logic busy, input logic osc);
    chk({tag, " com"}, 32'(bus.com_o), 32'(com));
    chk({tag, " min"}, 32'(bus.min_o), 32'(mn));
    chk({tag, " max"}, 32'(bus.max_o), 32'(mx));
    chk({tag, " val"}, 32'(bus.val_o), 32'(vo));
    chk({tag, " err"}, 32'(bus.cfg_err_o), 32'(err));
    chk({tag, " ready"}, 32'(bus.cfg_ready_o), 32'(rdy));
    chk({tag, " busy"}, 32'(bus.busy_o), 32'(busy));
    chk({tag, " osc"}, 32'(bus.osc_o), 32'(osc));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // Each row: inputs held for one clock, outputs expected after that edge.
    // Lamp test with a config held from cycle 2; accepted on the first RUN cycle.
    add(0, 0, 0, 0, 0, 0, 0,  3, 0, 15, 0, 0, 0, 1, 0); // e1
    add(1, 2, 5, 0, 0, 0, 0,  3, 0, 15, 0, 0, 0, 1, 0); // e2
    add(1, 2, 5, 0, 0, 0, 0,  2, 0, 15, 0, 0, 0, 1, 0); // e3
    add(1, 2, 5, 0, 0, 0, 0,  2, 0, 15, 0, 0, 0, 1, 1); // e4
    add(1, 2, 5, 0, 0, 0, 0,  2, 0, 15, 0, 0, 0, 1, 1); // e5
    add(1, 2, 5, 0, 0, 0, 0,  0, 0, 15, 0, 0, 1, 0, 1); // e6
    add(1, 2, 5, 0, 0, 0, 0,  0, 2,  5, 0, 0, 1, 0, 0); // e7 accept clears osc
    add(0, 0, 0, 0, 0, 0, 0,  0, 2,  5, 0, 0, 1, 0, 0); // e8
    add(0, 0, 0, 0, 0, 0, 0,  0, 2,  5, 0, 0, 1, 0, 0); // e9
    add(0, 0, 0, 0, 0, 0, 0,  0, 2,  5, 0, 0, 1, 0, 0); // e10
    add(0, 0, 0, 0, 0, 0, 0,  0, 2,  5, 0, 0, 1, 0, 1); // e11
    // Config 3/12, then the blink period.
    add(1, 3, 12, 0, 0, 0, 0, 0, 3, 12, 0, 0, 1, 0, 0); // e12
    add(0, 0, 0, 0, 0, 0, 0,  0, 3, 12, 0, 0, 1, 0, 0); // e13
    add(0, 0, 0, 0, 0, 0, 0,  0, 3, 12, 0, 0, 1, 0, 0); // e14
    add(0, 0, 0, 0, 0, 0, 0,  0, 3, 12, 0, 0, 1, 0, 0); // e15
    add(0, 0, 0, 0, 0, 0, 0,  0, 3, 12, 0, 0, 1, 0, 1); // e16
    add(0, 0, 0, 0, 0, 0, 0,  0, 3, 12, 0, 0, 1, 0, 1); // e17
    add(0, 0, 0, 0, 0, 0, 0,  0, 3, 12, 0, 0, 1, 0, 1); // e18
    add(0, 0, 0, 0, 0, 0, 0,  0, 3, 12, 0, 0, 1, 0, 1); // e19
    add(0, 0, 0, 0, 0, 0, 0,  0, 3, 12, 0, 0, 1, 0, 0); // e20
    // Rejected configs: equal, then inverted.
    add(1, 9, 9, 0, 0, 0, 0,  0, 3, 12, 0, 1, 1, 0, 0); // e21
    add(0, 0, 0, 0, 0, 0, 0,  0, 3, 12, 0, 0, 1, 0, 0); // e22
    add(1, 12, 3, 0, 0, 0, 0, 0, 3, 12, 0, 1, 1, 0, 0); // e23
    add(0, 0, 0, 0, 0, 0, 0,  0, 3, 12, 0, 0, 1, 0, 1); // e24
    // Linear mode, lamp test on request, requests ignored during the test.
    add(0, 0, 0, 0, 0, 1, 0,  1, 3, 12, 0, 0, 1, 0, 1); // e25
    add(0, 0, 0, 0, 0, 1, 1,  3, 3, 12, 0, 0, 0, 1, 1); // e26
    add(0, 0, 0, 0, 0, 1, 0,  3, 3, 12, 0, 0, 0, 1, 1); // e27
    add(0, 0, 0, 0, 0, 1, 1,  3, 3, 12, 0, 0, 0, 1, 0); // e28
    add(1, 1, 2, 0, 0, 1, 0,  2, 3, 12, 0, 0, 0, 1, 0); // e29
    add(0, 0, 0, 1, 15, 1, 0, 2, 3, 12, 15, 0, 0, 1, 0); // e30
    add(0, 0, 0, 0, 0, 1, 0,  2, 3, 12, 15, 0, 0, 1, 0); // e31
    add(0, 0, 0, 0, 0, 1, 0,  1, 3, 12, 15, 0, 1, 0, 1); // e32
    // Config + value + test request in one cycle.
    add(1, 1, 14, 1, 8, 1, 1, 3, 1, 14, 8, 0, 0, 1, 0); // e33
    add(0, 0, 0, 0, 0, 1, 0,  3, 1, 14, 8, 0, 0, 1, 0); // e34
    add(0, 0, 0, 0, 0, 1, 0,  3, 1, 14, 8, 0, 0, 1, 0); // e35
    add(0, 0, 0, 0, 0, 1, 0,  2, 1, 14, 8, 0, 0, 1, 0); // e36
    add(0, 0, 0, 0, 0, 1, 0,  2, 1, 14, 8, 0, 0, 1, 1); // e37
    add(0, 0, 0, 0, 0, 1, 0,  2, 1, 14, 8, 0, 0, 1, 1); // e38
    add(0, 0, 0, 0, 0, 1, 0,  1, 1, 14, 8, 0, 1, 0, 1); // e39
    add(0, 0, 0, 0, 0, 0, 0,  0, 1, 14, 8, 0, 1, 0, 1); // e40
    add(0, 0, 0, 0, 0, 0, 0,  0, 1, 14, 8, 0, 1, 0, 0); // e41
    add(0, 0, 0, 0, 0, 0, 0,  0, 1, 14, 8, 0, 1, 0, 0); // e42
    add(0, 0, 0, 0, 0, 0, 0,  0, 1, 14, 8, 0, 1, 0, 0); // e43
    add(0, 0, 0, 0, 0, 0, 0,  0, 1, 14, 8, 0, 1, 0, 0); // e44
    // Accept on the prescaler wrap: clear must beat the toggle.
    add(1, 3, 12, 0, 0, 0, 0, 0, 3, 12, 8, 0, 1, 0, 0); // e45
    add(0, 0, 0, 0, 0, 0, 0,  0, 3, 12, 8, 0, 1, 0, 0); // e46

    repeat (2) @(negedge clk);
    chk_all("reset", 2'b11, 4'd0, 4'd15, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].cv, vecs[i].cmin, vecs[i].cmax, vecs[i].vv, vecs[i].v, vecs[i].lin,
            vecs[i].treq);
      @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("e%0d", i + 1), vecs[i].com, vecs[i].mn, vecs[i].mx, vecs[i].vo,
              vecs[i].err, vecs[i].rdy, vecs[i].busy, vecs[i].osc);
    end

    // Asynchronous reset between edges must take effect without a clock.
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk_all("async_rst", 2'b11, 4'd0, 4'd15, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("relamp e0 com", 32'(bus.com_o), 32'd3);
    for (int e = 1; e <= 6; e++) begin
      logic [1:0] exp_com;
      logic       exp_osc;
      @(posedge clk);
      @(negedge clk);
      exp_com = (e <= 2) ? 2'b11 : (e <= 5) ? 2'b10 : 2'b00;
      exp_osc = (e >= 4);
      chk($sformatf("relamp e%0d com", e), 32'(bus.com_o), 32'(exp_com));
      chk($sformatf("relamp e%0d busy", e), 32'(bus.busy_o), 32'(e <= 5));
      chk($sformatf("relamp e%0d osc", e), 32'(bus.osc_o), 32'(exp_osc));
      chk($sformatf("relamp e%0d min", e), 32'(bus.min_o), 32'd0);
      chk($sformatf("relamp e%0d max", e), 32'(bus.max_o), 32'd15);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
